// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and defaults for the data-memory arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

    typedef logic port_idx_t;

    localparam int DEF_DEPTH    = 64;
    localparam int DEF_MAX_LOCK = 4;

    // Word index addr[31:2] must be below depth; byte offset bits are ignored.
    function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
        return {2'b00, addr[31:2]} < 32'(depth);
    endfunction

endpackage

// File: rtl/dmem_arb_rr.sv
// rtl/dmem_arb_rr.sv - combinational two-way round-robin picker
module dmem_arb_rr
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  port_idx_t  last_i,
    output logic [1:0] gnt_o
);

    // On a tie the port that was not granted last wins.
    assign gnt_o[0] = req_i[0] & (~req_i[1] | last_i);
    assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_i);

endmodule

// File: rtl/dmem_arb.sv
// rtl/dmem_arb.sv - two-port arbiter in front of the single-port data memory
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic        m0_lock,
    input  logic        m1_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        m0_rerr,
    output logic        m1_rerr,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [1:0] ST_IDLE = ARB_IDLE;
    localparam logic [1:0] ST_OWN0 = ARB_OWN0;
    localparam logic [1:0] ST_OWN1 = ARB_OWN1;

    logic [1:0]    state_q, state_d;
    port_idx_t     last_q, last_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic [1:0]    rvalid_q, rerr_q;
    logic [31:0]   rdata0_q, rdata1_q;

    logic [1:0]  req, lock, rr_gnt, gnt;
    port_idx_t   own_port;
    logic        own_valid, other_req, cnt_full;
    logic        sel_we, sel_ok;
    logic [31:0] rd_val;

    assign req  = {m1_req, m0_req};
    assign lock = {m1_lock, m0_lock};

    dmem_arb_rr u_rr (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (rr_gnt)
    );

    always_comb begin
        own_port   = (state_q == ST_OWN1);
        own_valid  = ((state_q == ST_OWN0) & m0_req & m0_lock)
                   | ((state_q == ST_OWN1) & m1_req & m1_lock);
        other_req  = own_port ? m0_req : m1_req;
        cnt_full   = (lock_cnt_q == CNT_MAX);
        gnt        = 2'b00;
        state_d    = ST_IDLE;
        lock_cnt_d = '0;
        last_d     = last_q;

        if (own_valid && (!cnt_full || !other_req)) begin
            gnt[own_port] = 1'b1;
            state_d       = state_q;
            lock_cnt_d    = cnt_full ? lock_cnt_q : lock_cnt_q + CNT_ONE;
        end else begin
            // An exhausted owner hands over to the waiter; otherwise plain round robin.
            if (own_valid) begin
                gnt = own_port ? 2'b01 : 2'b10;
            end else begin
                gnt = rr_gnt;
            end
            if (gnt[0] && m0_lock) begin
                state_d    = ST_OWN0;
                lock_cnt_d = CNT_ONE;
            end else if (gnt[1] && m1_lock) begin
                state_d    = ST_OWN1;
                lock_cnt_d = CNT_ONE;
            end
        end

        if (gnt != 2'b00) begin
            last_d = gnt[1];
        end
        if (reset) begin
            gnt = 2'b00;
        end
    end

    always_comb begin
        mem_a  = gnt[1] ? m1_addr  : m0_addr;
        mem_wd = gnt[1] ? m1_wdata : m0_wdata;
        sel_we = gnt[1] ? m1_we    : m0_we;
        sel_ok = addr_in_range(mem_a, DEPTH);
        mem_we = (|gnt) & sel_we & sel_ok;
        rd_val = ((|gnt) & ~sel_we & sel_ok) ? mem_rd : 32'h0;
    end

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
            rvalid_q   <= 2'b00;
            rerr_q     <= 2'b00;
            rdata0_q   <= 32'h0;
            rdata1_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid_q   <= gnt;
            rerr_q     <= gnt & {2{~sel_ok}};
            rdata0_q   <= gnt[0] ? rd_val : 32'h0;
            rdata1_q   <= gnt[1] ? rd_val : 32'h0;
        end
    end

    // A response still in flight when reset arrives is suppressed.
    assign m0_rvalid = rvalid_q[0] & ~reset;
    assign m1_rvalid = rvalid_q[1] & ~reset;
    assign m0_rerr   = rerr_q[0] & ~reset;
    assign m1_rerr   = rerr_q[1] & ~reset;
    assign m0_rdata  = reset ? 32'h0 : rdata0_q;
    assign m1_rdata  = reset ? 32'h0 : rdata1_q;

endmodule

// File: tb/tb_dmem_arb.sv
// tb/tb_dmem_arb.sv - randomized bench with a transaction-level arbiter and memory model
module tb_dmem_arb;

    localparam int DEPTH    = 64;
    localparam int MAX_LOCK = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rerr, m1_rerr;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    always #5 clk = ~clk;

    logic [31:0] dmem [0:63];
    assign mem_rd = dmem[mem_a[7:2]];
    always @(posedge clk) if (mem_we) dmem[mem_a[7:2]] <= mem_wd;

    dmem_arb #(.DEPTH(DEPTH), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_lock(m0_lock), .m1_lock(m1_lock),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_rerr(m0_rerr), .m1_rerr(m1_rerr),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: who holds the memory, how long, and who went last.
    int          owner = -1;
    int          streak = 0;
    int          last_port = 1;
    int          last_g = -1;
    logic [31:0] ref_mem [0:63];
    logic        ev [2];
    logic        ee [2];
    logic [31:0] ed [2];

    logic        o_g0, o_g1, o_we, o_rv0, o_rv1, o_re0, o_re1;
    logic [31:0] o_rd0, o_rd1;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic r0, input logic w0, input logic l0, input logic [31:0] a0,
                          input logic [31:0] d0, input logic r1, input logic w1, input logic l1,
                          input logic [31:0] a1, input logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    endtask

    // One clock: called just after a posedge with inputs set; checks at the negedge.
    task automatic step();
        logic        req [2];
        logic        lk [2];
        logic        we [2];
        logic [31:0] ad [2];
        logic [31:0] wd [2];
        int          g;
        bit          cont, ok;
        @(negedge clk);
        o_g0 = m0_gnt; o_g1 = m1_gnt; o_we = mem_we;
        o_rv0 = m0_rvalid; o_rv1 = m1_rvalid; o_re0 = m0_rerr; o_re1 = m1_rerr;
        o_rd0 = m0_rdata; o_rd1 = m1_rdata;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin ev[k] = 1'b0; ee[k] = 1'b0; ed[k] = 32'h0; end
        end
        chk1("m0_rvalid", m0_rvalid, ev[0]);
        chk1("m1_rvalid", m1_rvalid, ev[1]);
        chk1("m0_rerr", m0_rerr, ee[0]);
        chk1("m1_rerr", m1_rerr, ee[1]);
        chk32("m0_rdata", m0_rdata, ed[0]);
        chk32("m1_rdata", m1_rdata, ed[1]);

        req = '{m0_req, m1_req}; lk = '{m0_lock, m1_lock};
        we  = '{m0_we, m1_we};   ad = '{m0_addr, m1_addr}; wd = '{m0_wdata, m1_wdata};
        cont = (owner >= 0) && req[owner] && lk[owner];
        if (reset)                                          g = -1;
        else if (cont && (streak < MAX_LOCK || !req[1-owner])) g = owner;
        else if (cont)                                      g = 1 - owner;
        else if (req[0] && req[1])                          g = 1 - last_port;
        else if (req[0])                                    g = 0;
        else if (req[1])                                    g = 1;
        else                                                g = -1;

        chk1("m0_gnt", m0_gnt, g == 0);
        chk1("m1_gnt", m1_gnt, g == 1);
        ok = (g >= 0) && (int'(ad[g][31:2]) < DEPTH);
        chk1("mem_we", mem_we, (g >= 0) && we[g] && ok);
        if (g >= 0) chk32("mem_a", mem_a, ad[g]);

        for (int k = 0; k < 2; k++) begin
            ev[k] = (g == k);
            ee[k] = (g == k) && !ok;
            ed[k] = ((g == k) && !we[k] && ok) ? ref_mem[ad[k][7:2]] : 32'h0;
        end
        if (g >= 0 && we[g] && ok) ref_mem[ad[g][7:2]] = wd[g];

        if (reset) begin
            owner = -1; streak = 0; last_port = 1;
        end else if (g < 0) begin
            owner = -1; streak = 0;
        end else begin
            if (cont && g == owner) begin
                if (streak < MAX_LOCK) streak++;
            end else begin
                owner  = lk[g] ? g : -1;
                streak = lk[g] ? 1 : 0;
            end
            last_port = g;
        end
        last_g = g;
        @(posedge clk);
        #1;
    endtask

    logic        p_req [2];
    logic        p_we [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wd [2];
    logic        p_lock [2];

    function automatic logic [31:0] rand_addr();
        int    r;
        logic [29:0] w;
        r = int'($urandom_range(0, 19));
        if (r == 0)      w = 30'(64 + $urandom_range(0, 7));
        else if (r == 1) w = 30'd63;
        else if (r == 2) w = 30'h3fffffff;
        else             w = 30'($urandom_range(0, 15));
        return {w, 2'($urandom)};
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) begin dmem[i] = 32'h0; ref_mem[i] = 32'h0; end
        for (int k = 0; k < 2; k++) begin
            ev[k] = 1'b0; ee[k] = 1'b0; ed[k] = 32'h0; p_req[k] = 1'b0;
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        step();
        step();
        reset = 1'b0;

        // write then read-back through the other port
        set_in(1, 1, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0); step();
        chk1("t1_m0_gnt", o_g0, 1'b1);
        chk1("t1_mem_we", o_we, 1'b1);
        set_in(0, 0, 0, 0, 0, 1, 0, 0, 32'h10, 0); step();
        chk1("t1_m1_gnt", o_g1, 1'b1);
        chk1("t1_m0_rvalid", o_rv0, 1'b1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        chk1("t1_m1_rvalid", o_rv1, 1'b1);
        chk32("t1_m1_rdata", o_rd1, 32'hDEADBEEF);
        chk1("t1_m1_rerr", o_re1, 1'b0);

        // round robin without lock
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 0, 32'h10, 0, 1, 0, 0, 32'h14, 0); step();
            chk1("t2_m0_gnt", o_g0, (i % 2) == 0);
            chk1("t2_m1_gnt", o_g1, (i % 2) == 1);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        chk1("t2_m1_rvalid_tail", o_rv1, 1'b1);

        // lock starvation bound
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_in(i > 0, 0, 0, 32'h4, 0, 1, 0, 1, 32'h8, 0); step();
            chk1("t3_m1_gnt", o_g1, i < 4);
            chk1("t3_m0_gnt", o_g0, i == 4);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();

        // out-of-range write and read
        set_in(1, 1, 0, 32'h100, 32'h1, 0, 0, 0, 0, 0); step();
        chk1("t4_gnt", o_g0, 1'b1);
        chk1("t4_mem_we", o_we, 1'b0);
        set_in(1, 0, 0, 32'h100, 0, 0, 0, 0, 0, 0); step();
        chk1("t4_wr_rerr", o_re0, 1'b1);
        chk32("t4_wr_rdata", o_rd0, 32'h0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        chk1("t4_rd_rerr", o_re0, 1'b1);

        // reset in the middle of a lock
        set_in(0, 0, 0, 0, 0, 1, 1, 1, 32'h20, 32'h55); step(); step();
        set_in(1, 0, 0, 32'h20, 0, 1, 1, 1, 32'h20, 32'h66);
        reset = 1'b1; step(); reset = 1'b0;
        chk1("t5_rst_g0", o_g0, 1'b0);
        chk1("t5_rst_g1", o_g1, 1'b0);
        chk1("t5_rst_we", o_we, 1'b0);
        set_in(1, 0, 0, 32'h20, 0, 1, 0, 0, 32'h24, 0); step();
        chk1("t5_after_m0", o_g0, 1'b1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();

        // lock released early
        set_in(1, 0, 1, 32'h0, 0, 0, 0, 0, 0, 0); step();
        set_in(1, 0, 1, 32'h0, 0, 1, 0, 0, 32'h4, 0); step();
        chk1("t6_m0_second", o_g0, 1'b1);
        set_in(0, 0, 0, 0, 0, 1, 0, 0, 32'h4, 0); step();
        chk1("t6_m1_gnt", o_g1, 1'b1);
        set_in(1, 0, 0, 32'h0, 0, 1, 0, 0, 32'h8, 0); step();
        chk1("t6_idle_rr", o_g0, 1'b1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (p_req[k] && last_g == k) p_req[k] = 1'b0;
                if (!p_req[k] && ($urandom_range(0, 2) != 0)) begin
                    p_req[k]  = 1'b1;
                    p_we[k]   = 1'($urandom);
                    p_addr[k] = rand_addr();
                    p_wd[k]   = $urandom;
                end
                p_lock[k] = ($urandom_range(0, 9) < 7);
            end
            set_in(p_req[0], p_we[0], p_lock[0], p_addr[0], p_wd[0],
                   p_req[1], p_we[1], p_lock[1], p_addr[1], p_wd[1]);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
